// File: rtl/mult_share_ctrl_pkg.sv
// Shared definitions for the time-shared serial multiplier controller.
package mult_share_ctrl_pkg;

   // Controller FSM states.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StWait  = 2'd2
   } state_e;

   // Default widths shared with other controllers.
   localparam int unsigned DefNReq   = 4;
   localparam int unsigned DefWidthA = 16;
   localparam int unsigned DefWidthB = 16;

   // Serial length of the multiplier: B width rounded up to a power of two.
   function automatic int unsigned serial_len(input int unsigned width_b);
      return 32'd1 << $clog2(width_b);
   endfunction

endpackage

// File: rtl/mult_share_ctrl_mult.sv
// Serial shift-add multiplier: signed A times unsigned B, one B bit per cycle.
// No reset; a start pulse fully reinitialises it. rdy drops on the start edge
// and rises exactly serial_len(WIDTH_B) edges later.
module mult_share_ctrl_mult
   import mult_share_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH_A = DefWidthA,
   parameter int unsigned WIDTH_B = DefWidthB
) (
   input  logic                       clk_i,
   input  logic                       start_i,
   input  logic [WIDTH_A-1:0]         a_i,
   input  logic [WIDTH_B-1:0]         b_i,
   output logic                       rdy_o,
   output logic [WIDTH_A+WIDTH_B-1:0] y_o
);

   localparam int unsigned WidthY = WIDTH_A + WIDTH_B;
   localparam int unsigned CntW   = ($clog2(WIDTH_B) > 0) ? $clog2(WIDTH_B) : 1;
   localparam int unsigned LenL   = serial_len(WIDTH_B);
   localparam logic [CntW-1:0] CntLast = CntW'(LenL - 1);

   logic [WidthY-1:0]  r_mcand;
   logic [WIDTH_B-1:0] r_mplier;
   logic [WidthY-1:0]  r_acc;
   logic [CntW-1:0]    r_cnt;
   logic               r_run;
   logic               r_rdy;

   // Load on start, then add the shifted multiplicand for each set B bit.
   always_ff @(posedge clk_i) begin
      if (start_i) begin
         r_mcand  <= {{WIDTH_B{a_i[WIDTH_A-1]}}, a_i};
         r_mplier <= b_i;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_run    <= 1'b1;
         r_rdy    <= 1'b0;
      end else if (r_run) begin
         if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
         end
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CntW'(1);
         if (r_cnt == CntLast) begin
            r_run <= 1'b0;
            r_rdy <= 1'b1;
         end
      end
   end

   assign rdy_o = r_rdy;
   assign y_o   = r_acc;

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter sharing one serial signed multiplier among N_REQ
// requesters. Operands are latched at grant; the product comes back with a
// one-hot done pulse. All outputs are registered.
module mult_share_ctrl
   import mult_share_ctrl_pkg::*;
#(
   parameter int unsigned N_REQ   = DefNReq,
   parameter int unsigned WIDTH_A = DefWidthA,
   parameter int unsigned WIDTH_B = DefWidthB
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [N_REQ-1:0]           req_i,
   input  logic [N_REQ*WIDTH_A-1:0]   A_i,
   input  logic [N_REQ*WIDTH_B-1:0]   B_i,
   output logic [N_REQ-1:0]           grant_o,
   output logic [N_REQ-1:0]           done_o,
   output logic [WIDTH_A+WIDTH_B-1:0] result_o,
   output logic                       busy_o
);

   localparam int unsigned IdxW   = $clog2(N_REQ);
   localparam int unsigned WidthY = WIDTH_A + WIDTH_B;
   localparam logic [N_REQ-1:0] OneHot0 = N_REQ'(1);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [IdxW-1:0]    r_ptr;
   logic [WIDTH_A-1:0] r_a;
   logic [WIDTH_B-1:0] r_b;
   logic               r_start;
   logic [N_REQ-1:0]   r_grant;
   logic [N_REQ-1:0]   r_done;
   logic [WidthY-1:0]  r_result;
   logic               r_busy;

   logic               w_any_req;
   logic [N_REQ-1:0]   w_rot;
   logic [IdxW-1:0]    w_off;
   logic [IdxW-1:0]    w_pick;
   logic [WIDTH_A-1:0] w_a_sel;
   logic [WIDTH_B-1:0] w_b_sel;
   logic               w_load;
   logic               w_finish;
   logic               w_rdy;
   logic [WidthY-1:0]  w_y;

   assign w_any_req = |req_i;

   // Round-robin pick: rotate so ptr+1 is bit 0, take lowest set bit, unrotate.
   always_comb begin
      w_rot  = '0;
      w_off  = '0;
      w_pick = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_rot[i] = req_i[IdxW'((32'(r_ptr) + 32'd1 + 32'(i)) % N_REQ)];
      end
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = IdxW'(i);
         end
      end
      w_pick = IdxW'((32'(r_ptr) + 32'd1 + 32'(w_off)) % N_REQ);
   end

   // Operand mux for the picked requester.
   always_comb begin
      w_a_sel = '0;
      w_b_sel = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (IdxW'(k) == w_pick) begin
            w_a_sel = A_i[k*WIDTH_A +: WIDTH_A];
            w_b_sel = B_i[k*WIDTH_B +: WIDTH_B];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_any_req) w_state_nxt = StStart;
         StStart: w_state_nxt = StWait;
         StWait:  if (w_rdy) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // FSM output decode: grant/latch event and completion event.
   always_comb begin
      w_load   = 1'b0;
      w_finish = 1'b0;
      unique case (r_state)
         StIdle:  w_load = w_any_req;
         StStart: w_load = 1'b0;
         StWait:  w_finish = w_rdy;
         default: w_load = 1'b0;
      endcase
   end

   // Registered datapath and outputs driven by the decoded events.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_ptr    <= IdxW'(N_REQ - 1);
         r_a      <= '0;
         r_b      <= '0;
         r_start  <= 1'b0;
         r_grant  <= '0;
         r_done   <= '0;
         r_result <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_done  <= '0;
         r_start <= w_load;
         r_busy  <= (w_state_nxt != StIdle);
         if (w_load) begin
            r_a     <= w_a_sel;
            r_b     <= w_b_sel;
            r_ptr   <= w_pick;
            r_grant <= OneHot0 << w_pick;
         end
         if (w_finish) begin
            r_result <= w_y;
            r_done   <= OneHot0 << r_ptr;
            r_grant  <= '0;
         end
      end
   end

   mult_share_ctrl_mult #(
      .WIDTH_A (WIDTH_A),
      .WIDTH_B (WIDTH_B)
   ) u_mult (
      .clk_i   (clk_i),
      .start_i (r_start),
      .a_i     (r_a),
      .b_i     (r_b),
      .rdy_o   (w_rdy),
      .y_o     (w_y)
   );

   assign grant_o  = r_grant;
   assign done_o   = r_done;
   assign result_o = r_result;
   assign busy_o   = r_busy;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: directed cases with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_mult_share_ctrl;

   localparam int unsigned N  = 4;
   localparam int unsigned WA = 16;
   localparam int unsigned WB = 16;
   localparam int unsigned WY = 32;
   localparam int unsigned L  = 16;
   localparam int unsigned LAT = L + 2;
   localparam int unsigned PER = L + 3;

   logic            clk = 1'b0;
   logic            reset_i = 1'b1;
   logic [N-1:0]    req = '0;
   logic [N*WA-1:0] a_bus = '0;
   logic [N*WB-1:0] b_bus = '0;
   logic [N-1:0]    grant_o;
   logic [N-1:0]    done_o;
   logic [WY-1:0]   result_o;
   logic            busy_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mult_share_ctrl #(
      .N_REQ   (N),
      .WIDTH_A (WA),
      .WIDTH_B (WB)
   ) dut (
      .clk_i    (clk),
      .reset_i  (reset_i),
      .req_i    (req),
      .A_i      (a_bus),
      .B_i      (b_bus),
      .grant_o  (grant_o),
      .done_o   (done_o),
      .result_o (result_o),
      .busy_o   (busy_o)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [WY-1:0] product(input logic [WA-1:0] a, input logic [WB-1:0] b);
      longint p;
      p = longint'($signed(a)) * longint'({48'd0, b});
      return p[WY-1:0];
   endfunction

   function automatic int onehot_idx(input logic [N-1:0] v);
      int r;
      r = -1;
      for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   // Transaction-level model: a grant completes LAT edges later; the next
   // grant cannot happen on the completion edge.
   logic [N-1:0]  m_grant = '0;
   logic [N-1:0]  m_done = '0;
   logic [WY-1:0] m_result = '0;
   logic [WY-1:0] m_prod = '0;
   logic          m_busy = 1'b0;
   bit            m_active = 1'b0;
   int            m_ptr = N - 1;
   int            m_idx = 0;
   int            m_age = 0;

   always @(posedge clk) begin
      if (reset_i) begin
         m_active = 1'b0;
         m_ptr    = N - 1;
         m_grant  = '0;
         m_done   = '0;
         m_result = '0;
         m_busy   = 1'b0;
         m_age    = 0;
      end else begin
         m_done = '0;
         if (m_active) begin
            m_age++;
            if (m_age == LAT) begin
               m_done   = N'(1) << m_idx;
               m_result = m_prod;
               m_grant  = '0;
               m_busy   = 1'b0;
               m_active = 1'b0;
            end
         end else if (req != '0) begin
            bit found;
            found = 1'b0;
            for (int i = 1; i <= N; i++) begin
               if (!found && req[(m_ptr + i) % N]) begin
                  m_idx = (m_ptr + i) % N;
                  found = 1'b1;
               end
            end
            m_ptr    = m_idx;
            m_prod   = product(a_bus[m_idx*WA +: WA], b_bus[m_idx*WB +: WB]);
            m_grant  = N'(1) << m_idx;
            m_busy   = 1'b1;
            m_active = 1'b1;
            m_age    = 0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      check("cyc grant", 64'(grant_o), 64'(m_grant));
      check("cyc done", 64'(done_o), 64'(m_done));
      check("cyc result", 64'(result_o), 64'(m_result));
      check("cyc busy", 64'(busy_o), 64'(m_busy));
   end

   task automatic set_op(input int k, input logic [WA-1:0] a, input logic [WB-1:0] b);
      a_bus[k*WA +: WA] = a;
      b_bus[k*WB +: WB] = b;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while ((busy_o || grant_o != '0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({nm, " idle timeout"}, 64'(n < 200), 64'(1));
      @(negedge clk);
   endtask

   task automatic wait_grant(input string nm);
      int n;
      n = 0;
      while (grant_o == '0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({nm, " grant timeout"}, 64'(n < 200), 64'(1));
   endtask

   task automatic run_single(input string nm, input int k, input logic [WA-1:0] a,
                             input logic [WB-1:0] b, input logic [WY-1:0] exp);
      int lat;
      set_op(k, a, b);
      req[k] = 1'b1;
      wait_grant(nm);
      check({nm, " grant"}, 64'(grant_o), 64'(N'(1) << k));
      lat = 0;
      while (done_o == '0 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      req[k] = 1'b0;
      check({nm, " latency"}, 64'(lat), 64'(LAT));
      check({nm, " done"}, 64'(done_o), 64'(N'(1) << k));
      check({nm, " result"}, 64'(result_o), 64'(exp));
      @(negedge clk);
      check({nm, " done pulse"}, 64'(done_o), 64'(0));
   endtask

   int g_idx[8];
   int g_cyc[8];
   int g_cnt;

   task automatic collect_grants(input string nm, input int n);
      logic [N-1:0] prev;
      prev  = grant_o;
      g_cnt = 0;
      for (int c = 0; c < 600 && g_cnt < n; c++) begin
         @(negedge clk);
         if (grant_o != '0 && prev == '0) begin
            check({nm, " onehot"}, 64'($countones(grant_o)), 64'(1));
            g_idx[g_cnt] = onehot_idx(grant_o);
            g_cyc[g_cnt] = c;
            g_cnt++;
         end
         prev = grant_o;
      end
      check({nm, " grant count"}, 64'(g_cnt), 64'(n));
   endtask

   task automatic rand_op(input int k);
      logic [WA-1:0] a;
      logic [WB-1:0] b;
      a = WA'($urandom);
      b = WB'($urandom);
      case ($urandom_range(0, 5))
         0: a = 16'h8000;
         1: a = 16'h7FFF;
         2: b = 16'hFFFF;
         3: b = 16'h0000;
         default: ;
      endcase
      set_op(k, a, b);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_order[5];
      int dones;
      logic [WY-1:0] last_res;
      exp_order = '{0, 1, 2, 3, 0};

      // Model arithmetic pinned by hand-computed values.
      check("model -3*5", 64'(product(16'hFFFD, 16'd5)), 64'h0000_0000_FFFF_FFF1);
      check("model ext", 64'(product(16'h8000, 16'hFFFF)), 64'h0000_0000_8000_8000);

      reset_i = 1'b1;
      repeat (3) @(negedge clk);
      check("reset grant", 64'(grant_o), 64'(0));
      check("reset done", 64'(done_o), 64'(0));
      check("reset result", 64'(result_o), 64'(0));
      check("reset busy", 64'(busy_o), 64'(0));
      reset_i = 1'b0;

      // All requesting from reset: 0,1,2,3,0 spaced one issue period apart.
      req = '1;
      collect_grants("allreq", 5);
      for (int i = 0; i < 5; i++) begin
         check("allreq order", 64'(g_idx[i]), 64'(exp_order[i]));
         if (i > 0) check("allreq spacing", 64'(g_cyc[i] - g_cyc[i-1]), 64'(PER));
      end
      req = '0;
      wait_idle("allreq");

      run_single("neg", 0, 16'hFFFD, 16'd5, 32'hFFFF_FFF1);
      run_single("ext1", 2, 16'h8000, 16'hFFFF, 32'h8000_8000);
      run_single("ext0", 3, 16'h7FFF, 16'h0000, 32'h0);

      // Reset while waiting on the multiplier.
      set_op(0, 16'd7, 16'd6);
      req[0] = 1'b1;
      wait_grant("rstwait");
      repeat (6) @(negedge clk);
      reset_i = 1'b1;
      req     = '0;
      @(negedge clk);
      check("rstwait grant", 64'(grant_o), 64'(0));
      check("rstwait done", 64'(done_o), 64'(0));
      check("rstwait result", 64'(result_o), 64'(0));
      check("rstwait busy", 64'(busy_o), 64'(0));
      reset_i = 1'b0;
      run_single("after rst", 0, 16'd7, 16'd6, 32'd42);

      // Operand change after grant and request drop mid-operation.
      wait_idle("opchg");
      set_op(1, 16'd10, 16'd3);
      req[1] = 1'b1;
      wait_grant("opchg");
      set_op(1, 16'd100, 16'd9);
      repeat (5) @(negedge clk);
      req[1]   = 1'b0;
      dones    = 0;
      last_res = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done_o != '0) begin
            dones++;
            check("opchg done", 64'(done_o), 64'(4'b0010));
            last_res = result_o;
         end
      end
      check("opchg count", 64'(dones), 64'(1));
      check("opchg result", 64'(last_res), 64'(30));

      // Fairness: requesters 0 and 2 held; grants must alternate.
      set_op(0, 16'd3, 16'd3);
      set_op(2, 16'd5, 16'd5);
      req[0] = 1'b1;
      req[2] = 1'b1;
      collect_grants("fair", 6);
      check("fair first", 64'(g_idx[0] == 0 || g_idx[0] == 2), 64'(1));
      for (int i = 1; i < 6; i++) begin
         check("fair alternate", 64'(g_idx[i]), 64'(g_idx[i-1] == 0 ? 2 : 0));
      end
      req = '0;
      wait_idle("fair");

      // Randomized traffic checked by the per-cycle compare process.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         reset_i = ($urandom_range(0, 599) == 0);
         for (int k = 0; k < N; k++) begin
            if (m_done[k]) begin
               if ($urandom_range(0, 1) == 0) req[k] = 1'b0;
               else rand_op(k);
            end else if (!req[k]) begin
               if ($urandom_range(0, 7) == 0) begin
                  rand_op(k);
                  req[k] = 1'b1;
               end
            end else begin
               if ($urandom_range(0, 63) == 0) req[k] = 1'b0;
               if ($urandom_range(0, 15) == 0) rand_op(k);
            end
         end
         @(negedge clk);
      end
      reset_i = 1'b0;
      req     = '0;
      repeat (2 * PER) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
